// File: rtl/spi_slave_core.sv
// SPI responder: oversamples ss/sclk/mosi on PCLK, all CPOL/CPHA modes, MSB/LSB first.
// Optional receive-overrun flag is built when SPI_SLAVE_OVR_EN is defined.
module spi_slave_core (
   input  logic       PCLK,
   input  logic       PRESET,
   input  logic       cpol,
   input  logic       cpha,
   input  logic       lsbfe,
   input  logic       ss,
   input  logic       sclk,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       busy,
   output logic       rx_ovr
);

   typedef enum logic [0:0] {StIdle, StActive} state_e;

   state_e      state_q, state_d;
   logic [2:0]  ss_q, sclk_q;
   logic [1:0]  mosi_q;
   logic [2:0]  cnt_q;
   logic [7:0]  shift_q, rx_shift_q, buf_q, rx_data_q;
   logic        buf_full_q, rx_valid_q, miso_q;

   logic        ss_sync, ss_fall, lead_edge, trail_edge, active;
   logic        start, sample, shift_edge, done, load;
   logic [7:0]  load_byte, shift_next, rx_next;

   function automatic logic first_bit(input logic [7:0] b, input logic lsb);
      return lsb ? b[0] : b[7];
   endfunction

   assign ss_sync    = ss_q[1];
   // ss flops reset low, so a frame already in progress at reset is not re-entered
   assign ss_fall    = ss_q[2] & ~ss_q[1];
   assign lead_edge  = (sclk_q[2] == cpol) && (sclk_q[1] != cpol);
   assign trail_edge = (sclk_q[2] != cpol) && (sclk_q[1] == cpol);

   assign active     = (state_q == StActive) && !ss_sync;
   assign sample     = active && (cpha ? trail_edge : lead_edge);
   assign shift_edge = active && (cpha ? lead_edge : trail_edge);
   assign done       = sample && (cnt_q == 3'd7);
   assign load       = start || done;

   assign load_byte  = buf_full_q ? buf_q : 8'h00;
   assign shift_next = lsbfe ? {1'b0, shift_q[7:1]} : {shift_q[6:0], 1'b0};
   assign rx_next    = lsbfe ? {mosi_q[1], rx_shift_q[7:1]} : {rx_shift_q[6:0], mosi_q[1]};

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (ss_fall) begin
               state_d = StActive;
               start   = 1'b1;
            end
         end
         StActive: begin
            if (ss_sync) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         ss_q       <= 3'b000;
         sclk_q     <= 3'b000;
         mosi_q     <= 2'b00;
         cnt_q      <= 3'd0;
         shift_q    <= 8'h00;
         rx_shift_q <= 8'h00;
         buf_q      <= 8'h00;
         buf_full_q <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         miso_q     <= 1'b0;
      end else begin
         ss_q   <= {ss_q[1:0], ss};
         sclk_q <= {sclk_q[1:0], sclk};
         mosi_q <= {mosi_q[0], mosi};

         if (load) begin
            shift_q    <= load_byte;
            buf_full_q <= 1'b0;
         end
         // A write in the same cycle as a load lands in the buffer, not the shifter
         if (tx_valid && !buf_full_q) begin
            buf_q      <= tx_data;
            buf_full_q <= 1'b1;
         end
         if (start) begin
            cnt_q  <= 3'd0;
            miso_q <= cpha ? 1'b0 : first_bit(load_byte, lsbfe);
         end

         if (sample) begin
            rx_shift_q <= rx_next;
            cnt_q      <= cnt_q + 3'd1;
         end

         if (shift_edge) begin
            if (cpha) begin
               miso_q  <= first_bit(shift_q, lsbfe);
               shift_q <= shift_next;
            end else if (cnt_q == 3'd0) begin
               // Trailing edge after a byte boundary presents the reloaded byte's first bit
               miso_q <= first_bit(shift_q, lsbfe);
            end else begin
               miso_q  <= first_bit(shift_next, lsbfe);
               shift_q <= shift_next;
            end
         end

         if (done) begin
            rx_data_q  <= rx_next;
            rx_valid_q <= 1'b1;
         end else if (rx_ack) begin
            rx_valid_q <= 1'b0;
         end
      end
   end

`ifdef SPI_SLAVE_OVR_EN
   logic rx_ovr_q;
   always_ff @(posedge PCLK) begin
      if (PRESET)                  rx_ovr_q <= 1'b0;
      else if (rx_ack)             rx_ovr_q <= 1'b0;
      else if (done && rx_valid_q) rx_ovr_q <= 1'b1;
   end
   assign rx_ovr = rx_ovr_q;
`else
   assign rx_ovr = 1'b0;
`endif

   assign busy     = (state_q == StActive);
   assign miso_oe  = busy;
   assign miso     = busy ? miso_q : 1'b0;
   assign tx_ready = !buf_full_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: bit-level SPI master model, expected-byte queue scoreboard and
// directed scenarios. Define SPI_SLAVE_OVR_EN to exercise the overrun flag.
module tb_spi_slave_core;

   localparam int H = 8;   // sclk half-period in PCLK cycles

   logic       PCLK = 1'b0;
   logic       PRESET = 1'b1;
   logic       cpol = 1'b0, cpha = 1'b0, lsbfe = 1'b0;
   logic       ss = 1'b1, sclk = 1'b0, mosi = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0, rx_ack = 1'b0;
   logic       miso, miso_oe, tx_ready, rx_valid, busy, rx_ovr;
   logic [7:0] rx_data;

   int   checks = 0;
   int   errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] prev_rx_data = 8'h00;
   logic       prev_rx_valid = 1'b0;
   logic [7:0] mi, mi2;

   spi_slave_core dut (
      .PCLK     (PCLK),
      .PRESET   (PRESET),
      .cpol     (cpol),
      .cpha     (cpha),
      .lsbfe    (lsbfe),
      .ss       (ss),
      .sclk     (sclk),
      .mosi     (mosi),
      .miso     (miso),
      .miso_oe  (miso_oe),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ack   (rx_ack),
      .busy     (busy),
      .rx_ovr   (rx_ovr)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Every new rx byte must be the oldest byte the master finished sending
   always @(negedge PCLK) begin
      if (!PRESET) begin
         chk("oe_vs_busy", miso_oe, busy);
         if (!miso_oe) chk("miso_idle_low", miso, 1'b0);
`ifndef SPI_SLAVE_OVR_EN
         chk("ovr_disabled", rx_ovr, 1'b0);
`endif
         if (rx_valid && (!prev_rx_valid || rx_data != prev_rx_data)) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rx_unexpected: got 0x%0h expected no byte", rx_data);
            end else begin
               chk("rx_byte", rx_data, exp_q.pop_front());
            end
         end
      end
      prev_rx_valid <= rx_valid;
      prev_rx_data  <= rx_data;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge PCLK);
      #1;
   endtask

   task automatic tx_write(input logic [7:0] b);
      int n = 0;
      while (!tx_ready && n < 100) begin
         tick(1);
         n++;
      end
      chk("tx_ready_wait", tx_ready, 1'b1);
      tx_data  = b;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
   endtask

   task automatic ack();
      rx_ack = 1'b1;
      tick(1);
      rx_ack = 1'b0;
   endtask

   task automatic set_mode(input logic c, input logic p, input logic l);
      cpol  = c;
      cpha  = p;
      lsbfe = l;
      sclk  = c;
      tick(6);
   endtask

   task automatic frame_start();
      ss = 1'b0;
      tick(H);
   endtask

   task automatic frame_end();
      tick(H);
      ss = 1'b1;
      tick(2 * H);
   endtask

   // Master side of one byte; miso captured at the master's own sample edge
   task automatic spi_byte(input logic [7:0] mo, input int nbits, input bit push,
                           output logic [7:0] mo_in);
      mo_in = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         int idx;
         idx = lsbfe ? i : 7 - i;
         if (!cpha) begin
            mosi = mo[idx];
            tick(H);
            sclk = ~cpol;
            mo_in[idx] = miso;
            if (push && i == 7) exp_q.push_back(mo);
            tick(H);
            sclk = cpol;
         end else begin
            sclk = ~cpol;
            mosi = mo[idx];
            tick(H);
            sclk = cpol;
            mo_in[idx] = miso;
            if (push && i == 7) exp_q.push_back(mo);
            tick(H);
         end
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_miso"}, miso, 1'b0);
      chk({tag, "_miso_oe"}, miso_oe, 1'b0);
      chk({tag, "_tx_ready"}, tx_ready, 1'b1);
      chk({tag, "_rx_valid"}, rx_valid, 1'b0);
      chk({tag, "_rx_data"}, rx_data, 8'h00);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_rx_ovr"}, rx_ovr, 1'b0);
   endtask

   initial begin
      tick(5);
      PRESET = 1'b0;
      tick(2);
      chk_reset_values("por");

      // Mode 0, MSB first
      set_mode(1'b0, 1'b0, 1'b0);
      tx_write(8'hA9);
      chk("m0_tx_ready_low", tx_ready, 1'b0);
      frame_start();
      chk("m0_busy", busy, 1'b1);
      spi_byte(8'h90, 8, 1'b1, mi);
      chk("m0_miso_byte", mi, 8'hA9);
      frame_end();
      chk("m0_rx_data", rx_data, 8'h90);
      chk("m0_rx_valid", rx_valid, 1'b1);
      chk("m0_tx_ready", tx_ready, 1'b1);
      ack();
      chk("m0_ack_clears", rx_valid, 1'b0);

      // Mode 3, LSB first
      set_mode(1'b1, 1'b1, 1'b1);
      tx_write(8'h01);
      frame_start();
      spi_byte(8'h80, 8, 1'b1, mi);
      chk("m3_miso_byte", mi, 8'h01);
      frame_end();
      chk("m3_rx_data", rx_data, 8'h80);
      ack();

      // Back-to-back bytes in one frame
      set_mode(1'b0, 1'b0, 1'b0);
      tx_write(8'h12);
      frame_start();
      tx_write(8'h34);
      spi_byte(8'h55, 8, 1'b1, mi);
      chk("b2b_rx_first", rx_data, 8'h55);
      ack();
      spi_byte(8'hAA, 8, 1'b1, mi2);
      frame_end();
      chk("b2b_miso_first", mi, 8'h12);
      chk("b2b_miso_second", mi2, 8'h34);
      chk("b2b_rx_second", rx_data, 8'hAA);
      ack();

      // Abort after four bits, then a clean frame
      frame_start();
      spi_byte(8'hF0, 4, 1'b0, mi);
      tick(H);
      ss = 1'b1;
      tick(2 * H);
      chk("abort_rx_valid", rx_valid, 1'b0);
      chk("abort_busy", busy, 1'b0);
      frame_start();
      spi_byte(8'h3C, 8, 1'b1, mi);
      frame_end();
      chk("abort_next_rx", rx_data, 8'h3C);
      ack();

      // Two bytes without acknowledge
      frame_start();
      spi_byte(8'h11, 8, 1'b1, mi);
      spi_byte(8'h22, 8, 1'b1, mi);
      frame_end();
      chk("ovr_rx_data", rx_data, 8'h22);
      chk("ovr_rx_valid", rx_valid, 1'b1);
`ifdef SPI_SLAVE_OVR_EN
      chk("ovr_flag", rx_ovr, 1'b1);
`else
      chk("ovr_flag", rx_ovr, 1'b0);
`endif
      ack();
      chk("ovr_ack_valid", rx_valid, 1'b0);
      chk("ovr_ack_flag", rx_ovr, 1'b0);

      // Reset after three bits with ss held low
      tx_write(8'h5A);
      frame_start();
      tx_write(8'h66);
      chk("rst_tx_full", tx_ready, 1'b0);
      spi_byte(8'hC7, 3, 1'b0, mi);
      PRESET = 1'b1;
      tick(1);
      PRESET = 1'b0;
      chk_reset_values("midrst");
      spi_byte(8'hC7, 8, 1'b0, mi);
      tick(H);
      chk("rst_no_rx", rx_valid, 1'b0);
      chk("rst_idle", busy, 1'b0);
      ss = 1'b1;
      tick(2 * H);
      frame_start();
      spi_byte(8'hE1, 8, 1'b1, mi);
      frame_end();
      chk("rst_recover_rx", rx_data, 8'hE1);
      ack();

      tick(4);
      chk("rx_queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
